// File: rtl/fas_pkg.sv
// fas_pkg: shared constants, state encoding and bin word layout for fft_peak_detect
package fas_pkg;
  localparam int DW = 16;
  localparam int NBIN = 16;
  localparam int REAL_MSB = 31;
  localparam int REAL_LSB = 16;
  localparam int IMAG_MSB = 15;
  localparam int IMAG_LSB = 0;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    REPORT = 2'd2
  } state_t;
endpackage

// File: rtl/fft_peak_detect_if.sv
// fft_peak_detect_if: FFT frame bus in, peak report out
interface fft_peak_detect_if;
  logic fft_valid;
  logic [31:0] fft_d0, fft_d1, fft_d2, fft_d3, fft_d4, fft_d5, fft_d6, fft_d7;
  logic [31:0] fft_d8, fft_d9, fft_d10, fft_d11, fft_d12, fft_d13, fft_d14, fft_d15;
  logic busy;
  logic done;
  logic [3:0] freq;
  logic [31:0] peak_mag;
  logic overrun;
  modport master (
    output fft_valid, fft_d0, fft_d1, fft_d2, fft_d3, fft_d4, fft_d5, fft_d6, fft_d7,
           fft_d8, fft_d9, fft_d10, fft_d11, fft_d12, fft_d13, fft_d14, fft_d15,
    input busy, done, freq, peak_mag, overrun
  );
  modport slave (
    input fft_valid, fft_d0, fft_d1, fft_d2, fft_d3, fft_d4, fft_d5, fft_d6, fft_d7,
          fft_d8, fft_d9, fft_d10, fft_d11, fft_d12, fft_d13, fft_d14, fft_d15,
    output busy, done, freq, peak_mag, overrun
  );
endinterface

// File: rtl/mag_sq.sv
// mag_sq: unsigned re^2 + im^2; the -32768 corner sums to exactly 2^31
module mag_sq
  import fas_pkg::*;
(
  input  logic signed [DW-1:0] re,
  input  logic signed [DW-1:0] im,
  output logic [31:0] mag
);
  logic signed [2*DW-1:0] rr, ii;
  assign rr = re * re;
  assign ii = im * im;
  assign mag = $unsigned(rr) + $unsigned(ii);
endmodule

// File: rtl/fft_peak_detect.sv
// fft_peak_detect: latches a 16-bin frame, scans one bin per cycle, reports the strongest bin
module fft_peak_detect
  import fas_pkg::*;
(
  input logic clk,
  input logic rst,
  fft_peak_detect_if.slave fft
);
  state_t state_q, state_d;
  logic [31:0] bank [NBIN];
  logic [31:0] din [NBIN];
  logic [3:0] k, best_idx, nb_idx, freq_q;
  logic [31:0] best_mag, nb_mag, mag, peak_q;
  logic done_q, ovr_q, scan, take, capture, last;
  assign din = '{fft.fft_d0, fft.fft_d1, fft.fft_d2, fft.fft_d3, fft.fft_d4, fft.fft_d5,
                 fft.fft_d6, fft.fft_d7, fft.fft_d8, fft.fft_d9, fft.fft_d10, fft.fft_d11,
                 fft.fft_d12, fft.fft_d13, fft.fft_d14, fft.fft_d15};
  assign scan = state_q == SCAN;
  assign last = k == 4'(NBIN - 1);
  mag_sq u_mag (
    .re (bank[k][REAL_MSB:REAL_LSB]),
    .im (bank[k][IMAG_MSB:IMAG_LSB]),
    .mag(mag)
  );
  // REPORT accepts a new frame too, so only SCAN refuses the strobe
  always_comb begin
    capture = fft.fft_valid && !scan;
    take = k == 4'd0 || mag > best_mag;
    nb_mag = take ? mag : best_mag;
    nb_idx = take ? k : best_idx;
    state_d = scan ? (last ? REPORT : SCAN) : (capture ? SCAN : IDLE);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  // result registers load on the final scan edge so done is visible in the REPORT cycle
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bank <= '{default: '0};
      k <= '0;
      best_idx <= '0;
      best_mag <= '0;
      freq_q <= '0;
      peak_q <= '0;
      done_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      if (capture) begin
        bank <= din;
        k <= '0;
      end else if (scan) begin
        k <= k + 4'd1;
        best_mag <= nb_mag;
        best_idx <= nb_idx;
      end
      if (scan && last) begin
        freq_q <= nb_idx;
        peak_q <= nb_mag;
      end
      done_q <= scan && last;
      ovr_q <= scan && fft.fft_valid;
    end
  assign fft.busy = scan;
  assign fft.done = done_q;
  assign fft.freq = freq_q;
  assign fft.peak_mag = peak_q;
  assign fft.overrun = ovr_q;
endmodule

// File: tb/tb_fft_peak_detect.sv
// tb_fft_peak_detect: scenario tasks plus a done-driven scoreboard for fft_peak_detect
module tb_fft_peak_detect;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  fft_peak_detect_if bus ();
  fft_peak_detect dut (.clk(clk), .rst(rst), .fft(bus));
  int total = 0;
  int bad = 0;
  logic [35:0] sb [$];
  logic [31:0] fr [16];

  function automatic logic [35:0] expect_of(input logic [31:0] f [16]);
    longint re, im, m, bm;
    int bi;
    bm = -1;
    bi = 0;
    for (int i = 0; i < 16; i++) begin
      re = longint'($signed(f[i][31:16]));
      im = longint'($signed(f[i][15:0]));
      m = re * re + im * im;
      if (m > bm) begin
        bm = m;
        bi = i;
      end
    end
    return {4'(bi), 32'(bm)};
  endfunction

  always @(negedge clk)
    if (!rst && bus.done) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_done: got freq=%0d mag=%h, required no done", bus.freq, bus.peak_mag);
      end else begin
        logic [35:0] e;
        e = sb.pop_front();
        if ({bus.freq, bus.peak_mag} !== e) begin
          bad++;
          $display("FAIL sb_result: got freq=%0d mag=%h, required freq=%0d mag=%h",
                   bus.freq, bus.peak_mag, e[35:32], e[31:0]);
        end
      end
    end

  task automatic set_all(input logic [31:0] v);
    foreach (fr[i]) fr[i] = v;
  endtask

  task automatic drive_data(input bit rnd);
    logic [31:0] d [16];
    foreach (d[i]) d[i] = rnd ? $urandom : fr[i];
    bus.fft_d0 = d[0];   bus.fft_d1 = d[1];   bus.fft_d2 = d[2];   bus.fft_d3 = d[3];
    bus.fft_d4 = d[4];   bus.fft_d5 = d[5];   bus.fft_d6 = d[6];   bus.fft_d7 = d[7];
    bus.fft_d8 = d[8];   bus.fft_d9 = d[9];   bus.fft_d10 = d[10]; bus.fft_d11 = d[11];
    bus.fft_d12 = d[12]; bus.fft_d13 = d[13]; bus.fft_d14 = d[14]; bus.fft_d15 = d[15];
  endtask

  // caller sits just after a posedge; returns just after the capture edge with junk on the data bus
  task automatic strobe(input bit push);
    drive_data(1'b0);
    bus.fft_valid = 1'b1;
    if (push) sb.push_back(expect_of(fr));
    @(posedge clk);
    #1;
    bus.fft_valid = 1'b0;
    drive_data(1'b1);
  endtask

  task automatic test_reset;
    bus.fft_valid = 1'b0;
    drive_data(1'b1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({bus.busy, bus.done, bus.overrun} !== 3'b000) begin
      bad++;
      $display("FAIL reset_flags: got busy/done/overrun=%b, required 000", {bus.busy, bus.done, bus.overrun});
    end
    total++;
    if ({bus.freq, bus.peak_mag} !== 36'd0) begin
      bad++;
      $display("FAIL reset_result: got freq=%0d mag=%h, required 0/0", bus.freq, bus.peak_mag);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_busy: got %b, required 0", bus.busy);
    end
  endtask

  task automatic test_single_peak;
    int busy_bad = 0, done_n = 0, done_at = 0;
    set_all({16'h0010, 16'h0010});
    fr[5] = {16'h0100, 16'h0000};
    @(posedge clk);
    #1;
    strobe(1'b1);
    for (int i = 1; i <= 19; i++) begin
      @(negedge clk);
      if (bus.busy !== (i <= 16)) busy_bad++;
      if (bus.done) begin
        done_n++;
        done_at = i;
      end
    end
    total++;
    if (busy_bad != 0) begin
      bad++;
      $display("FAIL single_busy_window: got %0d wrong cycles, required 0", busy_bad);
    end
    total++;
    if (done_n != 1 || done_at != 17) begin
      bad++;
      $display("FAIL single_done_timing: got %0d pulses last at +%0d, required 1 at +17", done_n, done_at);
    end
    total++;
    if (bus.freq !== 4'd5 || bus.peak_mag !== 32'h0001_0000) begin
      bad++;
      $display("FAIL single_result: got freq=%0d mag=%h, required 5/00010000", bus.freq, bus.peak_mag);
    end
  endtask

  task automatic test_tie_sign;
    set_all(32'h0);
    fr[3] = {16'h0040, 16'h0000};
    fr[9] = {16'hFFC0, 16'h0000};
    @(posedge clk);
    #1;
    strobe(1'b1);
    repeat (19) @(negedge clk);
    total++;
    if (bus.freq !== 4'd3 || bus.peak_mag !== 32'h0000_1000) begin
      bad++;
      $display("FAIL tie_sign: got freq=%0d mag=%h, required 3/00001000", bus.freq, bus.peak_mag);
    end
  endtask

  task automatic test_all_zero;
    int done_n = 0;
    set_all(32'h0);
    @(posedge clk);
    #1;
    strobe(1'b1);
    for (int i = 1; i <= 19; i++) begin
      @(negedge clk);
      if (bus.done) done_n++;
    end
    total++;
    if (done_n != 1) begin
      bad++;
      $display("FAIL zero_done: got %0d pulses, required 1", done_n);
    end
    total++;
    if (bus.freq !== 4'd0 || bus.peak_mag !== 32'h0) begin
      bad++;
      $display("FAIL zero_result: got freq=%0d mag=%h, required 0/0", bus.freq, bus.peak_mag);
    end
  endtask

  task automatic test_extreme;
    set_all({16'h7FFF, 16'h0000});
    fr[15] = {16'h8000, 16'h8000};
    @(posedge clk);
    #1;
    strobe(1'b1);
    repeat (19) @(negedge clk);
    total++;
    if (bus.freq !== 4'd15 || bus.peak_mag !== 32'h8000_0000) begin
      bad++;
      $display("FAIL extreme: got freq=%0d mag=%h, required 15/80000000", bus.freq, bus.peak_mag);
    end
  endtask

  task automatic test_overrun;
    int done_n = 0, ovr_n = 0, ovr_at = -1;
    set_all({16'h0001, 16'h0000});
    fr[2] = {16'h0200, 16'h0000};
    @(posedge clk);
    #1;
    strobe(1'b1);
    repeat (4) @(posedge clk);
    #1;
    fr[2] = {16'h0001, 16'h0000};
    fr[7] = {16'h0300, 16'h0000};
    strobe(1'b0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (bus.overrun) begin
        ovr_n++;
        if (ovr_at < 0) ovr_at = i;
      end
      if (bus.done) done_n++;
    end
    total++;
    if (ovr_n != 1 || ovr_at != 0) begin
      bad++;
      $display("FAIL overrun_pulse: got %0d pulses first at +%0d, required 1 at +0", ovr_n, ovr_at);
    end
    total++;
    if (done_n != 1) begin
      bad++;
      $display("FAIL overrun_done_count: got %0d, required 1", done_n);
    end
    total++;
    if (bus.freq !== 4'd2 || bus.peak_mag !== 32'h0004_0000) begin
      bad++;
      $display("FAIL overrun_result: got freq=%0d mag=%h, required 2/00040000", bus.freq, bus.peak_mag);
    end
  endtask

  task automatic test_back_to_back;
    int done_n = 0, done_at = 0, ovr_n = 0;
    set_all(32'h0);
    fr[11] = {16'h0050, 16'h0000};
    @(posedge clk);
    #1;
    strobe(1'b1);
    repeat (16) @(posedge clk);
    #1;
    total++;
    if (bus.done !== 1'b1 || bus.freq !== 4'd11) begin
      bad++;
      $display("FAIL b2b_first_done: got done=%b freq=%0d, required 1/11", bus.done, bus.freq);
    end
    set_all({16'h0001, 16'h0001});
    fr[4] = {16'h0000, 16'hFF00};
    strobe(1'b1);
    for (int i = 1; i <= 19; i++) begin
      @(negedge clk);
      if (bus.overrun) ovr_n++;
      if (bus.done) begin
        done_n++;
        done_at = i;
      end
    end
    total++;
    if (done_n != 1 || done_at != 17 || ovr_n != 0) begin
      bad++;
      $display("FAIL b2b_second: got %0d done at +%0d overruns=%0d, required 1 at +17 overruns=0",
               done_n, done_at, ovr_n);
    end
    total++;
    if (bus.freq !== 4'd4 || bus.peak_mag !== 32'h0001_0000) begin
      bad++;
      $display("FAIL b2b_result: got freq=%0d mag=%h, required 4/00010000", bus.freq, bus.peak_mag);
    end
  endtask

  task automatic test_reset_mid_scan;
    int done_n = 0;
    set_all(32'h0);
    fr[6] = {16'h0123, 16'h0000};
    @(posedge clk);
    #1;
    strobe(1'b1);
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    total++;
    if ({bus.busy, bus.done, bus.overrun} !== 3'b000 || {bus.freq, bus.peak_mag} !== 36'd0) begin
      bad++;
      $display("FAIL mid_reset: got busy/done/ovr=%b freq=%0d mag=%h, required all 0",
               {bus.busy, bus.done, bus.overrun}, bus.freq, bus.peak_mag);
    end
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_all(32'h0);
    fr[13] = {16'h0000, 16'h0777};
    @(posedge clk);
    #1;
    strobe(1'b1);
    for (int i = 1; i <= 19; i++) begin
      @(negedge clk);
      if (bus.done) done_n++;
    end
    total++;
    if (done_n != 1 || bus.freq !== 4'd13 || bus.peak_mag !== 32'h0037_B951) begin
      bad++;
      $display("FAIL post_reset: got %0d done freq=%0d mag=%h, required 1 done 13/0037b951",
               done_n, bus.freq, bus.peak_mag);
    end
  endtask

  initial begin
    test_reset();
    test_single_peak();
    test_tie_sign();
    test_all_zero();
    test_extreme();
    test_overrun();
    test_back_to_back();
    test_reset_mid_scan();
    repeat (2) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover: got %0d pending results, required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
